sel_rr_arbiter: RTL and testbench
=================================

Name: sel_rr_arbiter

Overview:
- Registered round-robin arbiter sitting directly upstream of the two-input select mux (`data_a`/`data_b`, `sel_a`/`sel_b`).
- Converts two independent requests into a registered one-hot select pair `{sel_a, sel_b}`: exactly 2'b10, 2'b01 or 2'b00, never 2'b11.
- Because the select is one-hot and the idle code is explicit, the downstream mux can hold a defined default rather than infer a latch.
- Grants are held until the owner releases them or a hold limit expires, then passed fairly to the other requester.

Parameters:
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may own the grant while the other is requesting; legal range 1..255.
- `CNT_W`, default 8: width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous assert, active-low reset.
- `req_a`, input, 1: requester A wants the mux path.
- `req_b`, input, 1: requester B wants the mux path.
- `done`, input, 1: current owner releases the grant; sampled only while `busy` = 1.
- `sel_a`, output, 1: registered grant to A; drives the mux `sel_a`.
- `sel_b`, output, 1: registered grant to B; drives the mux `sel_b`.
- `busy`, output, 1: `sel_a | sel_b`, registered.
- `any_req`, output, 1: combinational `req_a | req_b`.
- `hold_cnt`, output, `CNT_W`: cycles the current grant has been held; 0 in IDLE.
- `preempt`, output, 1: one-cycle pulse when a grant is revoked by `HOLD_MAX` expiry.

Behaviour:
- Reset: while `rst_n` = 0, asynchronously force state = IDLE, `sel_a` = `sel_b` = 0, `busy` = 0, `hold_cnt` = 0, `preempt` = 0, `last` = B.
  - `last` is internal: the most recently granted requester. Resetting it to B gives A first priority after reset.
- Reset is honoured mid-grant; the grant drops with no completion cycle.
- States: IDLE, GNT_A, GNT_B. Outputs are decoded from registered state: `sel_a` = (state == GNT_A), `sel_b` = (state == GNT_B).
- IDLE transitions:
  - only `req_a` -> GNT_A; only `req_b` -> GNT_B.
  - both requesting -> grant the requester ≠ `last`.
  - neither -> stay in IDLE.
  - Latency: request sampled at edge N, `sel_*` = 1 after edge N (visible in cycle N+1).
- GNT_x (x owns the grant, y is the other requester), priority order of exits:
  1. `done` = 1 or `req_x` = 0: release. If `req_y` = 1, go directly to GNT_y (no idle bubble); otherwise go to IDLE. `hold_cnt` -> 0.
  2. `hold_cnt` == HOLD_MAX-1 and `req_y` = 1: preempt. Go to GNT_y, `preempt` = 1 for one cycle, `hold_cnt` -> 0.
  3. Otherwise stay in GNT_x. `hold_cnt` increments, saturating at HOLD_MAX-1 when `req_y` = 0. There is no preemption without a competing request.
- `last` updates to x on every entry into GNT_x.
- Simultaneous `done` and expiry: treat as release (exit 1); `preempt` stays 0.
- `done` while IDLE: ignored.
- Invariants (checked by assertion in the bench):
  - `sel_a & sel_b` == 0 in every cycle.
  - `sel_*` never changes except on a clock edge or on reset assertion.
- No combinational path from `req_*`/`done` to `sel_*`/`busy`/`hold_cnt`.

Test Plan:
- Reset then idle: `rst_n` low 3 cycles, then high with no requests -> `sel_a` = `sel_b` = 0, `busy` = 0, `hold_cnt` = 0 throughout.
- Single requester: `req_a` = 1 at cycle 5, `done` pulse at cycle 10 with `req_b` = 0 -> `sel_a` = 1 in cycles 6..10, IDLE from cycle 11; `hold_cnt` reads 0..4 over cycles 6..10.
- Simultaneous first request: `req_a` = `req_b` = 1 from reset release, `done` pulsed every 3rd cycle -> grants alternate A, B, A, B with no idle gap; `sel_a & sel_b` never 1.
- Preemption: `HOLD_MAX` = 4, `req_a` and `req_b` held high, no `done` -> A owns 4 cycles, `preempt` pulses once, B owns the next 4 cycles, then back to A.
- Collision: `done` asserted in the same cycle `hold_cnt` = 3 with `HOLD_MAX` = 4 -> grant passes to B, `preempt` = 0.
- Reset mid-grant: `rst_n` dropped asynchronously between edges during GNT_B -> `sel_b` = 0 immediately. After release with both requesting, A is granted first.

Source files
------------

// File: rtl/sel_rr_arbiter_if.sv
// Request/grant bundle between the two mux requesters and the round-robin select arbiter.
// The master side drives requests and done; the slave (arbiter) drives the one-hot select and status.
interface sel_rr_arbiter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_a;
    logic             req_b;
    logic             done;
    logic             sel_a;
    logic             sel_b;
    logic             busy;
    logic             any_req;
    logic [CNT_W-1:0] hold_cnt;
    logic             preempt;

    modport master (
        output req_a, req_b, done,
        input  sel_a, sel_b, busy, any_req, hold_cnt, preempt
    );

    modport slave (
        input  req_a, req_b, done,
        output sel_a, sel_b, busy, any_req, hold_cnt, preempt
    );
endinterface

// File: rtl/sel_rr_arbiter.sv
// Registered two-way round-robin arbiter producing a one-hot {sel_a, sel_b} for the downstream mux.
// Grants persist until released or until HOLD_MAX expires against a competing request.
module sel_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    sel_rr_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;
    logic             ownReq;
    logic             otherReq;
    state_e           otherState;

    // last_q = 1 means B was granted most recently, so A wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        preempt_d  = 1'b0;
        ownReq     = 1'b0;
        otherReq   = 1'b0;
        otherState = IDLE;

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (arb.req_a && arb.req_b) begin
                    state_d = last_q ? GNT_A : GNT_B;
                end else if (arb.req_a) begin
                    state_d = GNT_A;
                end else if (arb.req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                ownReq     = (state_q == GNT_A) ? arb.req_a : arb.req_b;
                otherReq   = (state_q == GNT_A) ? arb.req_b : arb.req_a;
                otherState = (state_q == GNT_A) ? GNT_B : GNT_A;
                // Release outranks expiry, so a done landing on the last allowed cycle never flags preempt.
                if (arb.done || !ownReq) begin
                    state_d = otherReq ? otherState : IDLE;
                    hold_d  = '0;
                end else if ((hold_q == HoldLast) && otherReq) begin
                    state_d   = otherState;
                    preempt_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q != HoldLast) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        if (state_d == GNT_A) begin
            last_d = 1'b0;
        end else if (state_d == GNT_B) begin
            last_d = 1'b1;
        end
    end

    assign arb.sel_a    = (state_q == GNT_A);
    assign arb.sel_b    = (state_q == GNT_B);
    assign arb.busy     = (state_q == GNT_A) || (state_q == GNT_B);
    assign arb.any_req  = arb.req_a | arb.req_b;
    assign arb.hold_cnt = hold_q;
    assign arb.preempt  = preempt_q;
endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Directed bench for sel_rr_arbiter (HOLD_MAX = 4): expected grants are queued at drive time
// and popped one cycle later, after the edge that should produce them.
module tb_sel_rr_arbiter;
    logic clk;
    logic rst_n;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic       selA;
        logic       selB;
        logic       anyReq;
        logic       preempt;
        logic [7:0] hold;
    } expT;

    expT expQ[$];

    sel_rr_arbiter_if #(.CNT_W(8)) arbIf ();

    sel_rr_arbiter #(
        .HOLD_MAX (4),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arbIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        if (expQ.size() == 0) begin
            compareValue({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        compareValue({tag, ".sel_a"},    32'(arbIf.sel_a),    32'(e.selA));
        compareValue({tag, ".sel_b"},    32'(arbIf.sel_b),    32'(e.selB));
        compareValue({tag, ".busy"},     32'(arbIf.busy),     32'(e.selA | e.selB));
        compareValue({tag, ".any_req"},  32'(arbIf.any_req),  32'(e.anyReq));
        compareValue({tag, ".hold_cnt"}, 32'(arbIf.hold_cnt), 32'(e.hold));
        compareValue({tag, ".preempt"},  32'(arbIf.preempt),  32'(e.preempt));
    endtask

    task automatic applyStimulus(input string tag, input logic reqA, input logic reqB, input logic doneIn,
                                 input logic expSelA, input logic expSelB, input logic [7:0] expHold,
                                 input logic expPreempt);
        arbIf.req_a = reqA;
        arbIf.req_b = reqB;
        arbIf.done  = doneIn;
        expQ.push_back('{selA: expSelA, selB: expSelB, anyReq: reqA | reqB, preempt: expPreempt, hold: expHold});
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Drops reset between edges and checks that everything clears without waiting for a clock.
    task automatic asyncResetPulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        compareValue({tag, ".sel_a"},    32'(arbIf.sel_a),    32'd0);
        compareValue({tag, ".sel_b"},    32'(arbIf.sel_b),    32'd0);
        compareValue({tag, ".busy"},     32'(arbIf.busy),     32'd0);
        compareValue({tag, ".hold_cnt"}, 32'(arbIf.hold_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            compareValue("mutex", 32'(arbIf.sel_a & arbIf.sel_b), 32'd0);
        end
    end

    initial begin
        rst_n       = 1'b0;
        arbIf.req_a = 1'b0;
        arbIf.req_b = 1'b0;
        arbIf.done  = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 0, 0, 0, 0, 0, 8'd0, 0);
        rst_n = 1'b1;
        applyStimulus("idle0", 0, 0, 0, 0, 0, 8'd0, 0);
        applyStimulus("idle1", 0, 0, 0, 0, 0, 8'd0, 0);

        applyStimulus("both1", 1, 1, 0, 1, 0, 8'd0, 0);
        applyStimulus("both2", 1, 1, 0, 1, 0, 8'd1, 0);
        applyStimulus("both3", 1, 1, 1, 0, 1, 8'd0, 0);
        applyStimulus("both4", 1, 1, 0, 0, 1, 8'd1, 0);
        applyStimulus("both5", 1, 1, 0, 0, 1, 8'd2, 0);
        applyStimulus("both6", 1, 1, 1, 1, 0, 8'd0, 0);
        applyStimulus("both7", 1, 1, 0, 1, 0, 8'd1, 0);
        applyStimulus("both8", 1, 1, 0, 1, 0, 8'd2, 0);
        applyStimulus("both9", 1, 1, 1, 0, 1, 8'd0, 0);
        applyStimulus("both10", 0, 0, 0, 0, 0, 8'd0, 0);

        applyStimulus("preA0", 1, 1, 0, 1, 0, 8'd0, 0);
        applyStimulus("preA1", 1, 1, 0, 1, 0, 8'd1, 0);
        applyStimulus("preA2", 1, 1, 0, 1, 0, 8'd2, 0);
        applyStimulus("preA3", 1, 1, 0, 1, 0, 8'd3, 0);
        applyStimulus("preB0", 1, 1, 0, 0, 1, 8'd0, 1);
        applyStimulus("preB1", 1, 1, 0, 0, 1, 8'd1, 0);
        applyStimulus("preB2", 1, 1, 0, 0, 1, 8'd2, 0);
        applyStimulus("preB3", 1, 1, 0, 0, 1, 8'd3, 0);
        applyStimulus("preA0b", 1, 1, 0, 1, 0, 8'd0, 1);
        applyStimulus("preA1b", 1, 1, 0, 1, 0, 8'd1, 0);
        applyStimulus("preA2b", 1, 1, 0, 1, 0, 8'd2, 0);
        applyStimulus("preA3b", 1, 1, 0, 1, 0, 8'd3, 0);
        applyStimulus("collide", 1, 1, 1, 0, 1, 8'd0, 0);
        applyStimulus("collideIdle", 0, 0, 0, 0, 0, 8'd0, 0);

        applyStimulus("singleA0", 1, 0, 0, 1, 0, 8'd0, 0);
        applyStimulus("singleA1", 1, 0, 0, 1, 0, 8'd1, 0);
        applyStimulus("singleA2", 1, 0, 0, 1, 0, 8'd2, 0);
        applyStimulus("singleA3", 1, 0, 0, 1, 0, 8'd3, 0);
        applyStimulus("singleSat", 1, 0, 0, 1, 0, 8'd3, 0);
        applyStimulus("singleDone", 1, 0, 1, 0, 0, 8'd0, 0);
        applyStimulus("singleIdle", 0, 0, 0, 0, 0, 8'd0, 0);
        applyStimulus("idleDone", 0, 0, 1, 0, 0, 8'd0, 0);

        applyStimulus("midB0", 0, 1, 0, 0, 1, 8'd0, 0);
        applyStimulus("midB1", 0, 1, 0, 0, 1, 8'd1, 0);
        asyncResetPulse("midRst");
        applyStimulus("postRstA0", 1, 1, 0, 1, 0, 8'd0, 0);
        applyStimulus("postRstA1", 1, 1, 0, 1, 0, 8'd1, 0);
        applyStimulus("postRstIdle", 0, 0, 0, 0, 0, 8'd0, 0);

        asyncResetPulse("idleRst");
        applyStimulus("lastRstA", 1, 1, 0, 1, 0, 8'd0, 0);
        applyStimulus("lastRstIdle", 0, 0, 0, 0, 0, 8'd0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
